// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and helpers for the 8-way round-robin mux arbiter.
// Defines the requester count, the select width, the FSM states and the one-hot decode.
package mux8_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first asserted request found when scanning upward from start, wrapping from 7 to 0.
module rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]   w_off;

    // Rotate so that bit 0 corresponds to the requester at 'start'.
    assign w_dbl = {req, req} >> start;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign w_rot[gi] = w_dbl[gi];
        end
    endgenerate

    always_comb begin
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SEL_W'(k);
            end
        end
    end

    assign found = |req;
    assign idx   = start + w_off;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that time-shares an 8:1 one-bit mux among 8 requesters.
// The hold counter bounds each grant's tenure; the granted bit is forwarded through a register.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] i,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             y,
    output logic             y_vld,
    output logic             busy
);

    state_t           r_state, w_state_next;
    logic [SEL_W-1:0] r_ptr, w_ptr_next;
    logic [SEL_W-1:0] r_sel, w_sel_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [N_REQ-1:0] r_gnt, w_gnt_next;
    logic             r_y, w_y_next;
    logic             r_y_vld, w_y_vld_next;

    logic             w_cur_req;
    logic             w_last;
    logic             w_release;
    logic [SEL_W-1:0] w_start;
    logic             w_found;
    logic [SEL_W-1:0] w_idx;

    assign w_cur_req = req[r_sel];
    assign w_last    = (r_cnt == CNT_W'(MAX_HOLD - 1));
    assign w_release = !w_cur_req || w_last;

    // While granting, the scan starts just past the current holder so it becomes lowest priority.
    assign w_start = (r_state == ST_GRANT) ? (r_sel + SEL_W'(1)) : r_ptr;

    rr_pick u_pick (
        .req   (req),
        .start (w_start),
        .found (w_found),
        .idx   (w_idx)
    );

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_sel_next   = r_sel;
        w_cnt_next   = r_cnt;
        w_gnt_next   = r_gnt;
        w_y_vld_next = (r_state == ST_GRANT) && w_cur_req;
        w_y_next     = w_y_vld_next && i[r_sel];

        case (r_state)
            ST_IDLE: begin
                w_gnt_next = '0;
                if (w_found) begin
                    w_state_next = ST_GRANT;
                    w_sel_next   = w_idx;
                    w_cnt_next   = '0;
                    w_gnt_next   = onehot(w_idx);
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_ptr_next = r_sel + SEL_W'(1);
                    if (w_found) begin
                        w_sel_next = w_idx;
                        w_cnt_next = '0;
                        w_gnt_next = onehot(w_idx);
                    end else begin
                        w_state_next = ST_IDLE;
                        w_gnt_next   = '0;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_y     <= 1'b0;
            r_y_vld <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_sel   <= w_sel_next;
            r_cnt   <= w_cnt_next;
            r_gnt   <= w_gnt_next;
            r_y     <= w_y_next;
            r_y_vld <= w_y_vld_next;
        end
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign y     = r_y;
    assign y_vld = r_y_vld;
    assign busy  = (r_state == ST_GRANT);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with hold limits of 4, 2 and 1.
// All three instances share stimulus; each scenario checks the relevant instance.
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] i;

    logic [7:0] gnt4, gnt2, gnt1;
    logic [2:0] sel4, sel2, sel1;
    logic       y4, y2, y1;
    logic       vld4, vld2, vld1;
    logic       busy4, busy2, busy1;

    int checks = 0;
    int errors = 0;

    mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .i(i),
        .gnt(gnt4), .sel(sel4), .y(y4), .y_vld(vld4), .busy(busy4)
    );

    mux8_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .i(i),
        .gnt(gnt2), .sel(sel2), .y(y2), .y_vld(vld2), .busy(busy2)
    );

    mux8_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .i(i),
        .gnt(gnt1), .sel(sel1), .y(y1), .y_vld(vld1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        i     = 8'h00;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        i     = 8'hFF;
        tick();
        tick();
        $display("reset: gnt=%h sel=%0d y=%b y_vld=%b busy=%b", gnt4, sel4, y4, vld4, busy4);
        checks++; if (gnt4 !== 8'h00) begin errors++; $display("FAIL reset_gnt got=%h exp=00", gnt4); end
        checks++; if (sel4 !== 3'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel4); end
        checks++; if (y4 !== 1'b0) begin errors++; $display("FAIL reset_y got=%b exp=0", y4); end
        checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL reset_y_vld got=%b exp=0", vld4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy4); end
        rst_n = 1'b1;
        tick();
        $display("reset release: gnt=%h sel=%0d", gnt4, sel4);
        checks++; if (gnt4 !== 8'h01) begin errors++; $display("FAIL reset_first_gnt got=%h exp=01", gnt4); end
        checks++; if (sel4 !== 3'd0) begin errors++; $display("FAIL reset_first_sel got=%0d exp=0", sel4); end
    endtask

    task automatic test_single_hold();
        logic bitv;
        do_reset();
        req = 8'h08;
        tick();
        checks++; if (gnt4 !== 8'h08) begin errors++; $display("FAIL single_first_gnt got=%h exp=08", gnt4); end
        checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL single_first_vld got=%b exp=0", vld4); end
        for (int k = 0; k < 12; k++) begin
            bitv = (k % 2 == 0);
            i    = {4'b0000, bitv, 3'b000} | 8'hF7 & {8{k[0]}};
            tick();
            $display("single k=%0d: gnt=%h sel=%0d y=%b y_vld=%b", k, gnt4, sel4, y4, vld4);
            checks++; if (gnt4 !== 8'h08) begin errors++; $display("FAIL single_gnt k=%0d got=%h exp=08", k, gnt4); end
            checks++; if (sel4 !== 3'd3) begin errors++; $display("FAIL single_sel k=%0d got=%0d exp=3", k, sel4); end
            checks++; if (vld4 !== 1'b1) begin errors++; $display("FAIL single_vld k=%0d got=%b exp=1", k, vld4); end
            checks++; if (y4 !== bitv) begin errors++; $display("FAIL single_y k=%0d got=%b exp=%b", k, y4, bitv); end
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp2 [12] = '{3'd0, 3'd0, 3'd4, 3'd4, 3'd7, 3'd7, 3'd0, 3'd0, 3'd4, 3'd4, 3'd7, 3'd7};
        logic [2:0] exp1 [12] = '{3'd0, 3'd4, 3'd7, 3'd0, 3'd4, 3'd7, 3'd0, 3'd4, 3'd7, 3'd0, 3'd4, 3'd7};
        do_reset();
        req = 8'h91;
        i   = 8'h91;
        for (int k = 0; k < 12; k++) begin
            tick();
            $display("rotate k=%0d: hold2 sel=%0d gnt=%h | hold1 sel=%0d gnt=%h", k, sel2, gnt2, sel1, gnt1);
            checks++; if (sel2 !== exp2[k]) begin errors++; $display("FAIL rot2_sel k=%0d got=%0d exp=%0d", k, sel2, exp2[k]); end
            checks++; if (gnt2 !== (8'h01 << exp2[k])) begin errors++; $display("FAIL rot2_gnt k=%0d got=%h", k, gnt2); end
            checks++; if (sel1 !== exp1[k]) begin errors++; $display("FAIL rot1_sel k=%0d got=%0d exp=%0d", k, sel1, exp1[k]); end
            if (k > 0) begin
                checks++; if (vld2 !== 1'b1) begin errors++; $display("FAIL rot2_vld k=%0d got=%b exp=1", k, vld2); end
                checks++; if (y2 !== 1'b1) begin errors++; $display("FAIL rot2_y k=%0d got=%b exp=1", k, y2); end
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 8'h06;
        i   = 8'h00;
        tick();
        checks++; if (gnt4 !== 8'h02) begin errors++; $display("FAIL early_first_gnt got=%h exp=02", gnt4); end
        tick();
        checks++; if (vld4 !== 1'b1) begin errors++; $display("FAIL early_vld1 got=%b exp=1", vld4); end
        req = 8'h04;
        tick();
        $display("early release: gnt=%h sel=%0d y_vld=%b", gnt4, sel4, vld4);
        checks++; if (sel4 !== 3'd2) begin errors++; $display("FAIL early_sel got=%0d exp=2", sel4); end
        checks++; if (gnt4 !== 8'h04) begin errors++; $display("FAIL early_gnt got=%h exp=04", gnt4); end
        checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL early_vld_drop got=%b exp=0", vld4); end
        i = 8'h04;
        tick();
        checks++; if (vld4 !== 1'b1 || y4 !== 1'b1) begin errors++; $display("FAIL early_after got vld=%b y=%b exp=1/1", vld4, y4); end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h40;
        tick();
        checks++; if (gnt4 !== 8'h40) begin errors++; $display("FAIL wrap_first_gnt got=%h exp=40", gnt4); end
        req = 8'h41;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (gnt4 !== 8'h40) begin errors++; $display("FAIL wrap_hold k=%0d got=%h exp=40", k, gnt4); end
        end
        tick();
        $display("wrap: gnt=%h sel=%0d", gnt4, sel4);
        checks++; if (sel4 !== 3'd0) begin errors++; $display("FAIL wrap_sel got=%0d exp=0", sel4); end
        checks++; if (gnt4 !== 8'h01) begin errors++; $display("FAIL wrap_gnt got=%h exp=01", gnt4); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h20;
        i   = 8'h20;
        for (int k = 0; k < 5; k++) tick();
        checks++; if (gnt4 !== 8'h20) begin errors++; $display("FAIL mid_pre_gnt got=%h exp=20", gnt4); end
        rst_n = 1'b0;
        tick();
        $display("mid reset: gnt=%h y_vld=%b busy=%b", gnt4, vld4, busy4);
        checks++; if (gnt4 !== 8'h00) begin errors++; $display("FAIL mid_gnt got=%h exp=00", gnt4); end
        checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL mid_vld got=%b exp=0", vld4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy4); end
        rst_n = 1'b1;
        req   = 8'hFF;
        tick();
        checks++; if (gnt4 !== 8'h01) begin errors++; $display("FAIL mid_ptr_gnt got=%h exp=01", gnt4); end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        i     = 8'h00;
        test_reset();
        test_single_hold();
        test_rotation();
        test_early_release();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
